// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: Moore controller sequencing fetch, PC update, decode and
// execute for the 16-bit ISA. All outputs are decoded from the state register.
module cpu_control_fsm #(
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         opcode,
  input  logic [1:0]         op,
  output logic               load_ir,
  output logic               load_pc,
  output logic               reset_pc,
  output logic               addr_sel,
  output logic               load_addr,
  output logic [1:0]         mem_cmd,
  output logic [2:0]         nsel,
  output logic [1:0]         vsel,
  output logic               write,
  output logic               loada,
  output logic               loadb,
  output logic               asel,
  output logic               bsel,
  output logic               loadc,
  output logic               loads,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_RST    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_IF1    = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_IF2    = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_UPC    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_DEC    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_WR_IMM = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_GET_B  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_PASS   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_WR_C   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_GET_A  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_ADDR   = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_LDA    = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_RD1    = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_RD2    = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_GET_D  = STATE_W'(15);
  localparam logic [STATE_W-1:0] S_WR_M   = STATE_W'(16);
  localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(17);
  // CMP is the EXEC cycle of op=01, split out so that the choice between
  // loads and loadc depends on state alone rather than on the live op field.
  localparam logic [STATE_W-1:0] S_CMP    = STATE_W'(18);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  assign state = state_q;

  // State register; reset forces RST immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next-state logic; IR fields are stable from UPC onward, so later states
  // may branch on opcode/op to pick the instruction-specific path.
  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    state_d = S_IF2;
      S_IF2:    state_d = S_UPC;
      S_UPC:    state_d = S_DEC;
      S_DEC: begin
        casez ({opcode, op})
          5'b110_10: state_d = S_WR_IMM;
          5'b110_00: state_d = S_GET_B;
          5'b101_??: state_d = S_GET_A;
          5'b011_00: state_d = S_GET_A;
          5'b100_00: state_d = S_GET_A;
          5'b111_??: state_d = S_HALT;
          default:   state_d = S_IF1;
        endcase
      end
      S_WR_IMM: state_d = S_IF1;
      S_GET_A:  state_d = (opcode == 3'b101) ? S_GET_B : S_ADDR;
      S_GET_B: begin
        if (opcode == 3'b101) state_d = (op == 2'b01) ? S_CMP : S_EXEC;
        else                  state_d = S_PASS;
      end
      S_PASS:   state_d = (opcode == 3'b100) ? S_WR_M : S_WR_C;
      S_EXEC:   state_d = S_WR_C;
      S_CMP:    state_d = S_IF1;
      S_WR_C:   state_d = S_IF1;
      S_ADDR:   state_d = S_LDA;
      S_LDA:    state_d = (opcode == 3'b100) ? S_GET_D : S_RD1;
      S_RD1:    state_d = S_RD2;
      S_RD2:    state_d = S_IF1;
      S_GET_D:  state_d = S_PASS;
      S_WR_M:   state_d = S_IF1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end

  // Moore output decode; unused encodings behave like RST.
  always_comb begin
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPC:    load_pc = 1'b1;
      S_DEC:    ;
      S_WR_IMM: begin
        nsel  = 3'b001;
        vsel  = 2'b10;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = 3'b001;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      S_PASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_EXEC:   loadc = 1'b1;
      S_CMP:    loads = 1'b1;
      S_WR_C: begin
        nsel  = 3'b010;
        vsel  = 2'b00;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LDA:    load_addr = 1'b1;
      S_RD1:    mem_cmd = MEM_READ;
      S_RD2: begin
        mem_cmd = MEM_READ;
        nsel    = 3'b010;
        vsel    = 2'b11;
        write   = 1'b1;
      end
      S_GET_D: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_WR_M:   mem_cmd = MEM_WRITE;
      S_HALT:   halted = 1'b1;
      default: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
    endcase
  end

endmodule
